// File: rtl/fsk_tx_ctrl.sv
// fsk_tx_ctrl: frames bytes as start/8 data LSB-first/stop bits, times bit periods and drives FSK carriers
module fsk_tx_ctrl #(
  parameter int CLK_PER_BIT = 200,
  parameter int F0_HALF     = 8,
  parameter int F1_HALF     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       bit_out,
  output logic       bit_clk,
  output logic       carrier_f0,
  output logic       carrier_f1,
  output logic       busy,
  output logic       frame_done
);
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int W0 = $clog2(F0_HALF + 1);
  localparam int W1 = $clog2(F1_HALF + 1);
  localparam logic [BW-1:0] LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLK_PER_BIT / 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic [W0-1:0] c0;
  logic [W1-1:0] c1;
  logic end_bit, end0, end1;
  assign end_bit  = bcnt == LAST;
  assign end0     = c0 == W0'(F0_HALF - 1);
  assign end1     = c1 == W1'(F1_HALF - 1);
  assign tx_ready = rst && enable && state == IDLE;
  assign busy     = state != IDLE;
  assign bit_out  = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
  // next-state, bit timer, bit index and shift register
  always_comb begin
    state_n = state;
    bcnt_n  = state == IDLE ? '0 : end_bit ? '0 : bcnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        shreg_n = tx_data;
        idx_n   = '0;
        state_n = START;
      end
      START: if (end_bit) begin
        idx_n   = '0;
        state_n = DATA;
      end
      DATA: if (end_bit) begin
        shreg_n = shreg >> 1;
        idx_n   = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: state_n = end_bit ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // frame state, strobe outputs registered from next-state values so they align with bit_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      idx        <= '0;
      shreg      <= '0;
      bit_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      bit_clk    <= state_n != IDLE && bcnt_n < HALF;
      frame_done <= state == STOP && end_bit;
    end
  end
  // free-running carrier dividers, independent of framing and enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0         <= '0;
      c1         <= '0;
      carrier_f0 <= 1'b0;
      carrier_f1 <= 1'b0;
    end else begin
      c0         <= end0 ? '0 : c0 + 1'b1;
      c1         <= end1 ? '0 : c1 + 1'b1;
      carrier_f0 <= end0 ? ~carrier_f0 : carrier_f0;
      carrier_f1 <= end1 ? ~carrier_f1 : carrier_f1;
    end
  end
endmodule

// File: tb/tb_fsk_tx_ctrl.sv
// tb_fsk_tx_ctrl: randomized and directed checks of fsk_tx_ctrl against a timeline model
module tb_fsk_tx_ctrl;
  localparam int N  = 8;
  localparam int F0 = 8;
  localparam int F1 = 4;
  logic clk = 0, rst = 0, enable = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, bit_out, bit_clk, carrier_f0, carrier_f1, busy, frame_done;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, fstart = -1, done_at = -1, n_frames = 0;
  logic [9:0] fb = '1;

  fsk_tx_ctrl #(.CLK_PER_BIT(N), .F0_HALF(F0), .F1_HALF(F1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bit_out(bit_out), .bit_clk(bit_clk), .carrier_f0(carrier_f0),
    .carrier_f1(carrier_f1), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_frame(input int c);
    return fstart >= 1 && c >= fstart && c < fstart + 10 * N;
  endfunction

  task automatic check_reset_vals();
    check("rst_bit_out", 32'(bit_out), 1);
    check("rst_bit_clk", 32'(bit_clk), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ready", 32'(tx_ready), 0);
    check("rst_f0", 32'(carrier_f0), 0);
    check("rst_f1", 32'(carrier_f1), 0);
  endtask

  task automatic tick();
    bit hs;
    logic [7:0] d;
    int k;
    bit inf;
    hs = rst && enable && tx_valid && !in_frame(cyc);
    d  = tx_data;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      fstart  = cyc;
      done_at = cyc + 10 * N;
      fb      = {1'b1, d, 1'b0};
    end
    inf = in_frame(cyc);
    k   = inf ? (cyc - fstart) / N : 0;
    if (frame_done) n_frames++;
    check("bit_out", 32'(bit_out), inf ? 32'(fb[k]) : 1);
    check("bit_clk", 32'(bit_clk), 32'(inf && ((cyc - fstart) % N) < N / 2));
    check("busy", 32'(busy), 32'(inf));
    check("frame_done", 32'(frame_done), 32'(cyc == done_at));
    check("tx_ready", 32'(tx_ready), 32'(enable && !inf));
    check("carrier_f0", 32'(carrier_f0), 32'((cyc / F0) % 2));
    check("carrier_f1", 32'(carrier_f1), 32'((cyc / F1) % 2));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1;
    cyc = 0;
    fstart = -1;
    done_at = -1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    release_rst();
    run(3);
    enable = 1;
    run(2);
    tx_data = 8'hA5;
    tx_valid = 1;
    tick();
    tx_valid = 0;
    tx_data = 8'h00;
    run(10 * N + 5);
    check("a5_frames", 32'(n_frames), 1);
    tx_data = 8'h00;
    tx_valid = 1;
    tick();
    run(10 * N);
    tx_data = 8'hFF;
    run(10 * N + 1);
    tx_valid = 0;
    run(5);
    check("b2b_frames", 32'(n_frames), 3);
    tx_data = 8'h5A;
    tx_valid = 1;
    run(3 * N + N / 2);
    enable = 0;
    run(10 * N * 2);
    check("en_drop_frames", 32'(n_frames), 4);
    enable = 1;
    run(10 * N + 3);
    check("en_back_frames", 32'(n_frames), 5);
    tx_valid = 0;
    run(10 * N);
    for (int i = 0; i < 3000; i++) begin
      tx_valid = 1'($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      tick();
    end
    enable = 1;
    tx_valid = 1;
    tx_data = 8'h3C;
    run(2 * N + 3);
    tx_valid = 0;
    run(2 * N);
    rst = 0;
    #1;
    check_reset_vals();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    release_rst();
    run(10 * N + 20);
    tx_valid = 1;
    tx_data = 8'h3C;
    tick();
    tx_valid = 0;
    run(10 * N + 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
